booth_radix4_core: RTL

//  Sequential signed radix-4 Booth multiplier core. Sits directly downstream of toggle_word.
//  - Sends the latched multiplicand to toggle_word.
//  - Receives the inverted word back and adds 1 to form -M.
//  - Accumulates one Booth digit per cycle to produce the signed product.

---
 rtl/booth_radix4_core.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/booth_radix4_core.sv
// Sequential signed radix-4 Booth multiplier.
// The latched multiplicand is sent to an external toggle_word block, which
// returns ~M; -M is formed from it, and then one Booth digit is accumulated
// per cycle until the product is ready.
module booth_radix4_core #(
    parameter int BITLEN      = 4,
    parameter int TOG_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BITLEN-1:0]     in_mcand,
    input  logic [BITLEN-1:0]     in_mplier,
    input  logic                  in_start_pulse,
    output logic [BITLEN-1:0]     tog_word,
    output logic                  tog_req_pulse,
    input  logic [BITLEN-1:0]     in_tog,
    input  logic                  in_tog_valid_pulse,
    output logic                  mod_busy,
    output logic [2*BITLEN-1:0]   out_prod,
    output logic                  out_prod_valid_pulse,
    output logic                  out_err_pulse
);

    localparam int PW  = 2 * BITLEN;
    localparam int IW  = (BITLEN / 2 > 1) ? $clog2(BITLEN / 2) : 1;
    localparam int TCW = $clog2(TOG_TIMEOUT + 1);

    localparam logic [IW-1:0]  LAST_DIGIT = IW'(BITLEN / 2 - 1);
    localparam logic [TCW-1:0] TCNT_LAST  = TCW'(TOG_TIMEOUT - 1);
    localparam logic [BITLEN:0] ONE_N     = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BITLEN-1:0] mcand_q, mcand_d;
    logic [BITLEN:0]   mx_q, mx_d;        // {mplier, 0}, shifted right 2 per digit
    logic [PW-1:0]     mc_sh_q, mc_sh_d;  // +M, pre-shifted by 2i
    logic [PW-1:0]     ng_sh_q, ng_sh_d;  // -M, pre-shifted by 2i
    logic [PW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     it_q, it_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic              busy_q, busy_d;
    logic              req_q, req_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [BITLEN:0]   negm;
    logic [PW-1:0]     term;

    // Extra bit keeps -(-2^(BITLEN-1)) representable.
    assign negm = {in_tog[BITLEN-1], in_tog} + ONE_N;

    // Booth digit selection on the current triplet; the operands are kept
    // pre-shifted, so the triplet is always the low three bits of mx_q.
    always_comb begin
        term = '0;
        case (mx_q[2:0])
            3'b001, 3'b010: term = mc_sh_q;
            3'b011:         term = mc_sh_q << 1;
            3'b100:         term = ng_sh_q << 1;
            3'b101, 3'b110: term = ng_sh_q;
            default:        term = '0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mx_d    = mx_q;
        mc_sh_d = mc_sh_q;
        ng_sh_d = ng_sh_q;
        acc_d   = acc_q;
        it_d    = it_q;
        tcnt_d  = tcnt_q;
        busy_d  = busy_q;
        req_d   = 1'b0;
        prod_d  = prod_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_start_pulse) begin
                    mcand_d = in_mcand;
                    mx_d    = {in_mplier, 1'b0};
                    mc_sh_d = {{BITLEN{in_mcand[BITLEN-1]}}, in_mcand};
                    busy_d  = 1'b1;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (in_tog_valid_pulse) begin
                    ng_sh_d = {{(BITLEN-1){negm[BITLEN]}}, negm};
                    acc_d   = '0;
                    it_d    = '0;
                    tcnt_d  = '0;
                    state_d = S_ITER;
                end else if (tcnt_q == TCNT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    tcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end
            S_ITER: begin
                acc_d   = acc_q + term;
                mx_d    = mx_q >> 2;
                mc_sh_d = mc_sh_q << 2;
                ng_sh_d = ng_sh_q << 2;
                it_d    = it_q + IW'(1);
                // The result is registered with the last digit so the valid
                // strobe is visible during the FIN cycle itself.
                if (it_q == LAST_DIGIT) begin
                    prod_d  = acc_q + term;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            mx_q    <= '0;
            mc_sh_q <= '0;
            ng_sh_q <= '0;
            acc_q   <= '0;
            it_q    <= '0;
            tcnt_q  <= '0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            prod_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mx_q    <= mx_d;
            mc_sh_q <= mc_sh_d;
            ng_sh_q <= ng_sh_d;
            acc_q   <= acc_d;
            it_q    <= it_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign tog_word             = mcand_q;
    assign tog_req_pulse        = req_q;
    assign mod_busy             = busy_q;
    assign out_prod             = prod_q;
    assign out_prod_valid_pulse = valid_q;
    assign out_err_pulse        = err_q;

endmodule
